// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// active-low column strobe patterns and key_code field widths.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int ROW_IDX_W  = 2;
  localparam int COL_IDX_W  = 2;
  localparam int KEY_CODE_W = ROW_IDX_W + COL_IDX_W;

  localparam logic [3:0] COL0     = 4'b1110;
  localparam logic [3:0] COL1     = 4'b1101;
  localparam logic [3:0] COL2     = 4'b1011;
  localparam logic [3:0] COL3     = 4'b0111;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  function automatic logic [3:0] col_strobe(input logic [COL_IDX_W-1:0] idx);
    logic [3:0] strobe;
    case (idx)
      2'd0:    strobe = COL0;
      2'd1:    strobe = COL1;
      2'd2:    strobe = COL2;
      default: strobe = COL3;
    endcase
    return strobe;
  endfunction

  // Lowest-indexed active-low row; only meaningful when some row is low.
  function automatic logic [ROW_IDX_W-1:0] lowest_low_row(input logic [3:0] rows);
    logic [ROW_IDX_W-1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Scan-rate divider: one-cycle tick every SCAN_DIV clocks, counter wraps
// to zero on the tick cycle.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, debounces press and release
// of a single key and reports it as {row, col} with a one-clock valid pulse.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [3:0]           row_meta_p0;
  logic [3:0]           row_sync_p1;
  logic                 tick;
  state_t               state;
  logic [COL_IDX_W-1:0] col_idx;
  logic [ROW_IDX_W-1:0] lat_row;
  logic [COL_IDX_W-1:0] lat_col;
  logic [CNT_W-1:0]     deb_cnt;
  logic [CNT_W-1:0]     rel_cnt;

  logic                 any_low;
  logic [ROW_IDX_W-1:0] low_row;
  logic                 lat_still_low;
  logic                 lat_high;
  logic [COL_IDX_W-1:0] col_next;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_p0 <= 4'b1111;
      row_sync_p1 <= 4'b1111;
    end else begin
      row_meta_p0 <= row_in;
      row_sync_p1 <= row_meta_p0;
    end
  end

  assign any_low       = (row_sync_p1 != COL_IDLE);
  assign low_row       = lowest_low_row(row_sync_p1);
  assign lat_still_low = any_low && (low_row == lat_row);
  assign lat_high      = row_sync_p1[lat_row];
  assign col_next      = col_idx + 2'd1;

  // Detected key position is pure data, captured once at the detecting tick
  always_ff @(posedge clk) begin
    if (tick && (state == ST_SCAN) && any_low) begin
      lat_row <= low_row;
      lat_col <= col_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      col_out   <= COL0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (any_low) begin
              if (DEB_MAX == ONE) begin
                key_code  <= {low_row, col_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                rel_cnt   <= '0;
                state     <= ST_HELD;
              end else begin
                deb_cnt <= ONE;
                state   <= ST_DEBOUNCE;
              end
            end else begin
              col_idx <= col_next;
              col_out <= col_strobe(col_next);
            end
          end

          ST_DEBOUNCE: begin
            if (lat_still_low) begin
              if ((deb_cnt + ONE) == DEB_MAX) begin
                key_code  <= {lat_row, lat_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                rel_cnt   <= '0;
                state     <= ST_HELD;
              end else begin
                deb_cnt <= deb_cnt + ONE;
              end
            end else begin
              deb_cnt <= '0;
              col_idx <= col_next;
              col_out <= col_strobe(col_next);
              state   <= ST_SCAN;
            end
          end

          // Other rows are ignored while held: only the latched row matters
          ST_HELD: begin
            if (lat_high) begin
              if (DEB_MAX == ONE) begin
                rel_cnt  <= '0;
                key_held <= 1'b0;
                col_idx  <= col_next;
                col_out  <= col_strobe(col_next);
                state    <= ST_SCAN;
              end else begin
                rel_cnt <= ONE;
                state   <= ST_RELEASE;
              end
            end
          end

          ST_RELEASE: begin
            if (lat_high) begin
              if ((rel_cnt + ONE) == DEB_MAX) begin
                rel_cnt  <= '0;
                key_held <= 1'b0;
                col_idx  <= col_next;
                col_out  <= col_strobe(col_next);
                state    <= ST_SCAN;
              end else begin
                rel_cnt <= rel_cnt + ONE;
              end
            end else begin
              rel_cnt <= '0;
              state   <= ST_HELD;
            end
          end

          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_TICKS=3) with a
// behavioural key matrix driving row_in from col_out.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int v0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is strobed
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_held_low(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (key_held === 1'b0) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Returns at the negedge right after col_out switches to target
  task automatic wait_col(input string tag, input logic [3:0] target, input int budget);
    logic [3:0] prev;
    bit found = 1'b0;
    prev = col_out;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (col_out === target && prev !== target) found = 1'b1;
      prev = col_out;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    reset   = 1'b0;
    pressed = '0;

    // Reset values
    step(3);
    check("rst_col_out", 32'(col_out), 32'h0E);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);

    // Idle scanning: column advances on every 4th edge after release
    reset = 1'b1;
    v0 = vcount;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      case (k)
        3:  check("idle_col_k3", 32'(col_out), 32'h0E);
        4:  check("idle_col_k4", 32'(col_out), 32'h0D);
        7:  check("idle_col_k7", 32'(col_out), 32'h0D);
        8:  check("idle_col_k8", 32'(col_out), 32'h0B);
        12: check("idle_col_k12", 32'(col_out), 32'h07);
        16: check("idle_col_k16", 32'(col_out), 32'h0E);
        default: ;
      endcase
    end
    check("idle_no_valid", 32'(vcount - v0), 32'd0);

    // Row 2 / column 2 held for 30 ticks
    v0 = vcount;
    pressed[2][2] = 1'b1;
    wait_valid("k22_valid_timeout", 200);
    check("k22_code", 32'(key_code), 32'h0A);
    check("k22_held", 32'(key_held), 32'h1);
    step(1);
    check("k22_valid_pulse", 32'(key_valid), 32'h0);
    step(120);
    check("k22_one_valid", 32'(vcount - v0), 32'd1);
    check("k22_still_held", 32'(key_held), 32'h1);
    check("k22_col_frozen", 32'(col_out), 32'h0B);
    pressed[2][2] = 1'b0;
    step(10);
    check("k22_held_rel10", 32'(key_held), 32'h1);
    step(4);
    check("k22_held_rel14", 32'(key_held), 32'h0);
    check("k22_col_next", 32'(col_out), 32'h07);
    check("k22_code_kept", 32'(key_code), 32'h0A);

    // Row 1 / column 0 bounce lasting only two ticks
    v0 = vcount;
    wait_col("bounce_col_timeout", 4'b1110, 40);
    pressed[1][0] = 1'b1;
    step(8);
    check("bounce_col_frozen", 32'(col_out), 32'h0E);
    pressed[1][0] = 1'b0;
    step(5);
    check("bounce_col_next", 32'(col_out), 32'h0D);
    check("bounce_not_held", 32'(key_held), 32'h0);
    check("bounce_no_valid", 32'(vcount - v0), 32'd0);

    // Rows 0 and 3 together under column 3: row 0 wins
    v0 = vcount;
    pressed[0][3] = 1'b1;
    pressed[3][3] = 1'b1;
    wait_valid("k03_valid_timeout", 200);
    check("k03_code", 32'(key_code), 32'h03);
    pressed[0][3] = 1'b0;
    pressed[3][3] = 1'b0;
    wait_held_low("k03_release_timeout", 40);
    check("k03_one_valid", 32'(vcount - v0), 32'd1);

    // One-tick release glitch while held must not release the key
    v0 = vcount;
    pressed[1][1] = 1'b1;
    wait_valid("k11_valid_timeout", 200);
    check("k11_code", 32'(key_code), 32'h05);
    pressed[1][1] = 1'b0;
    step(4);
    pressed[1][1] = 1'b1;
    step(2);
    check("glitch_held_in_release", 32'(key_held), 32'h1);
    step(18);
    check("glitch_still_held", 32'(key_held), 32'h1);
    check("glitch_one_valid", 32'(vcount - v0), 32'd1);
    pressed[1][1] = 1'b0;
    step(9);
    check("glitch_relcnt_reset", 32'(key_held), 32'h1);
    step(4);
    check("glitch_released", 32'(key_held), 32'h0);

    // Reset during DEBOUNCE with the key still down
    wait_col("rstdeb_col_timeout", 4'b1110, 40);
    v0 = vcount;
    pressed[0][0] = 1'b1;
    step(6);
    reset = 1'b0;
    #1;
    check("rstdeb_col_out", 32'(col_out), 32'h0E);
    check("rstdeb_key_code", 32'(key_code), 32'h0);
    check("rstdeb_key_valid", 32'(key_valid), 32'h0);
    check("rstdeb_key_held", 32'(key_held), 32'h0);
    step(3);
    reset = 1'b1;
    step(11);
    check("rstdeb_no_early_valid", 32'(key_valid), 32'h0);
    check("rstdeb_not_held", 32'(key_held), 32'h0);
    step(1);
    check("rstdeb_valid", 32'(key_valid), 32'h1);
    check("rstdeb_held", 32'(key_held), 32'h1);
    check("rstdeb_code", 32'(key_code), 32'h0);
    step(2);
    check("rstdeb_one_valid", 32'(vcount - v0), 32'd1);
    pressed[0][0] = 1'b0;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, default 50000, clk cycles per scan tick (minimum 2).
REQ-002 DEBOUNCE_TICKS, default 4, consecutive matching tick samples needed to accept a press or a release (minimum 1).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_out  output  4  column strobes, active-low one-hot, registered.
REQ-007 key_code  output  4  accepted key, {row_index[1:0], col_index[1:0]}, registered.
REQ-008 key_valid  output  1  one-clk pulse per accepted press.
REQ-009 key_held  output  1  high while an accepted key has not yet been released.

Function
REQ-010 The block SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 The block SHALL assert the internal tick for one cycle when the divider counter equals SCAN_DIV-1, then wrap the counter to 0.
REQ-012 States SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-013 In SCAN, on each tick, the block SHALL sample rows, then advance col_out 1110->1101->1011->0111->1110 if no row is low.
REQ-014 In SCAN, if any sampled row is low at a tick, the block SHALL latch the column index and the lowest-indexed low row, freeze col_out, set deb_cnt=1 and enter DEBOUNCE.
REQ-015 In DEBOUNCE, at each tick, if the latched row is still the lowest low row, deb_cnt SHALL increment; otherwise the block SHALL return to SCAN and advance the column.
REQ-016 When deb_cnt reaches DEBOUNCE_TICKS, the block SHALL load key_code, pulse key_valid for exactly one cycle (the cycle after that tick edge) and enter HELD.
REQ-017 If DEBOUNCE_TICKS=1, acceptance SHALL occur on the detecting tick directly from SCAN.
REQ-018 key_held SHALL be 1 in HELD and RELEASE and 0 in SCAN and DEBOUNCE.
REQ-019 In HELD, a tick with the latched row high SHALL set rel_cnt=1 and enter RELEASE; other rows going low SHALL be ignored (no rollover).
REQ-020 In RELEASE, each tick with the latched row high SHALL increment rel_cnt; a tick with it low SHALL return to HELD with rel_cnt=0.
REQ-021 When rel_cnt reaches DEBOUNCE_TICKS, the block SHALL enter SCAN and advance col_out to the next column.
REQ-022 key_code SHALL hold its last accepted value until the next acceptance.
REQ-023 No second key_valid SHALL occur without an intervening completed release.

Reset
REQ-024 While reset=0, the block SHALL force state SCAN, col_out=4'b1110, key_code=0, key_valid=0, key_held=0, divider, deb_cnt and rel_cnt to 0, and synchronizer flops to 4'b1111.
REQ-025 Reset asserted mid-press SHALL abort all states without emitting key_valid; after deassertion a still-held key SHALL be re-detected as a new press.

Structure
REQ-026 A shared package SHALL hold the state enumeration, column one-hot constants (COL0..COL3, COL_IDLE=4'b1111) and the key_code field widths.
REQ-027 The divider/tick generator SHALL be a sub-module named scan_tick_gen (ports clk, reset, tick; parameter SCAN_DIV).

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-028 Reset then idle rows 4'b1111 for 40 cycles -> col_out cycles 1110,1101,1011,0111 changing every 4 clks; key_valid never high.
REQ-029 Row 2 low whenever col_out=1011, held 30 ticks -> exactly one key_valid, key_code=4'b1010, key_held high until 3 ticks after release.
REQ-030 Row 1 low for only 2 ticks under column 0 -> no key_valid; SCAN resumes at col_out=1101.
REQ-031 Rows 0 and 3 low together under column 3 -> key_code=4'b0011 (row 0 wins).
REQ-032 During HELD, toggle the latched row high for 1 tick then low -> no release and no second key_valid; rel_cnt resets.
REQ-033 Assert reset during DEBOUNCE with the key held, then release reset -> outputs at reset values, then one key_valid after 3 qualifying ticks.
